seg7_scanner: RTL

Time-multiplexed 7-segment display driver downstream of the computer core's test_out bus. It takes the 32-bit debug word selected by test_sel and shows it as hexadecimal digits on a common-anode multiplexed display, one digit at a time. A frame-start snapshot prevents tearing while the CPU keeps updating test_out. Used on FPGA boards and in simulation benches alongside the core.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_hexdec.sv | 11 +
 rtl/seg7_scanner.sv | 87 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared hex font table and nibble-to-segment lookup
package seg7_pkg;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
        return HEX_FONT[nibble];
    endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// rtl/seg7_hexdec.sv - combinational nibble to active-high 7-segment decoder
module seg7_hexdec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - multiplexed hex display driver with per-frame input snapshot
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned PRESCALE       = 1000,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data,
    input  logic [WIDTH/4-1:0]   dp_mask,
    input  logic                 blank_zeros,
    output logic [WIDTH/4-1:0]   an,
    output logic [6:0]           seg,
    output logic                 dp
);

    localparam int unsigned DIGITS = WIDTH / 4;
    localparam int unsigned CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  snap_data;
    logic [DIGITS-1:0] snap_dp;
    logic              snap_bz;

    logic [WIDTH-1:0]  shifted;
    logic [6:0]        font_seg;
    logic [DIGITS-1:0] an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    // Shifting the current digit down to bit 0 gives both its nibble and the
    // "everything above is zero" test used for leading-zero blanking.
    assign shifted = snap_data >> {idx, 2'b00};

    seg7_hexdec u_hexdec (
        .nibble (shifted[3:0]),
        .seg    (font_seg)
    );

    always_comb begin
        an_d  = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        if (cnt != '0) begin
            an_d[idx] = 1'b1;
            dp_d      = snap_dp[idx];
            if (!(snap_bz && idx != '0 && shifted == '0)) begin
                seg_d = font_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            snap_data <= '0;
            snap_dp   <= '0;
            snap_bz   <= 1'b0;
            an        <= {DIGITS{AN_ACTIVE_LOW}};
            seg       <= {7{SEG_ACTIVE_LOW}};
            dp        <= SEG_ACTIVE_LOW;
        end else begin
            if (cnt == CNT_W'(PRESCALE - 1)) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Frame start: freeze the inputs so a changing test_out cannot tear
            if (cnt == '0 && idx == '0) begin
                snap_data <= data;
                snap_dp   <= dp_mask;
                snap_bz   <= blank_zeros;
            end
            an  <= an_d ^ {DIGITS{AN_ACTIVE_LOW}};
            seg <= seg_d ^ {7{SEG_ACTIVE_LOW}};
            dp  <= dp_d ^ SEG_ACTIVE_LOW;
        end
    end

endmodule
